// File: rtl/an_dec_seq.sv
// Sequential AN-code decoder: divides the codeword by A, then searches single
// and (optionally) double arithmetic errors bit-serially, re-dividing the repaired word.
module an_dec_seq #(
  parameter int A      = 18613,
  parameter int A_BITS = 15,
  parameter int W_BITS = 46,
  parameter int N_BITS = 31,
  parameter int L_BITS = 6,
  parameter int DEC_EN = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W_BITS-1:0]        W,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_BITS-1:0]        N,
  output logic [1:0]               status,
  output logic signed [L_BITS:0]   pos1,
  output logic signed [L_BITS:0]   pos2
);

  // Handshake: a word moves when in_valid && in_ready (IDLE only); a result is
  // held while out_valid and is released on the edge where out_ready is high.

  localparam logic [A_BITS-1:0] A_V = A_BITS'(A);
  localparam int XW = W_BITS + 2;
  localparam int CW = $clog2(W_BITS + 1);

  typedef enum logic [2:0] {IDLE, DIV, CHK, SEC, DEC_O, DEC_I, FIX, OUT} state_t;

  state_t                     state_q, state_d;
  logic [W_BITS-1:0]          w_q, w_d, div_q, div_d;
  logic [A_BITS-1:0]          rem_q, rem_d, r_q, r_d, p_q, p_d, p2_q, p2_d, t_q, t_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [N_BITS-1:0]          q_q, q_d, n_q, n_d;
  logic [L_BITS-1:0]          i_q, i_d, j_q, j_d;
  logic                       sgn_q, sgn_d;
  logic [1:0]                 status_q, status_d;
  logic signed [L_BITS:0]     pos1_q, pos1_d, pos2_q, pos2_d;

  function automatic logic [A_BITS-1:0] dbl_mod(input logic [A_BITS-1:0] x);
    logic [A_BITS:0] y;
    y = {x, 1'b0};
    if (y >= {1'b0, A_V}) y = y - {1'b0, A_V};
    return A_BITS'(y);
  endfunction

  function automatic logic signed [XW-1:0] err_val(input logic [L_BITS-1:0] k, input logic neg);
    logic signed [XW-1:0] m;
    m = $signed(XW'(1) << (k - 1'b1));
    return neg ? -m : m;
  endfunction

  function automatic logic signed [L_BITS:0] pos_of(input logic [L_BITS-1:0] k, input logic neg);
    logic signed [L_BITS:0] v;
    v = $signed({1'b0, k});
    return neg ? -v : v;
  endfunction

  // One restoring-division step, shared by DIV and FIX
  logic [A_BITS:0]     div_sh, div_sub;
  logic                div_ge, div_last;
  logic [A_BITS-1:0]   div_rem_n;
  logic [W_BITS-1:0]   div_q_n;

  always_comb begin
    div_sh    = {rem_q, div_q[W_BITS-1]};
    div_sub   = div_sh - {1'b0, A_V};
    div_ge    = (div_sh >= {1'b0, A_V});
    div_rem_n = A_BITS'(div_ge ? div_sub : div_sh);
    div_q_n   = {div_q[W_BITS-2:0], div_ge};
    div_last  = (cnt_q == CW'(W_BITS - 1));
  end

  // Candidate matches and the repaired word W' = W - e1 - e2
  logic                  sec_hit_p, sec_hit_m, dec_hit_p, dec_hit_m, cand_ok;
  logic signed [XW-1:0]  e1, e2, cand;
  logic [A_BITS:0]       tsum;
  logic [A_BITS-1:0]     t_n;

  always_comb begin
    sec_hit_p = (r_q == p_q);
    sec_hit_m = (r_q == A_V - p_q);
    dec_hit_p = (t_q == p2_q);
    dec_hit_m = (t_q == A_V - p2_q);
    e1 = '0;
    e2 = '0;
    if (state_q == SEC) begin
      e1 = err_val(i_q, sec_hit_m);
    end else if (state_q == DEC_I) begin
      e1 = err_val(i_q, sgn_q);
      e2 = err_val(j_q, dec_hit_m);
    end
    cand    = $signed({2'b00, w_q}) - e1 - e2;
    cand_ok = (cand[XW-1:XW-2] == 2'b00);
    // t = (R - e1) mod A; a negative e1 adds 2^(i-1) back
    tsum = sgn_q ? ({1'b0, r_q} + {1'b0, p_q}) : ({1'b0, r_q} + {1'b0, A_V - p_q});
    if (tsum >= {1'b0, A_V}) tsum = tsum - {1'b0, A_V};
    t_n = A_BITS'(tsum);
  end

  logic dec_adv, start_fix;

  always_comb begin
    state_d = state_q;  w_d = w_q;      div_d = div_q;   rem_d = rem_q;
    cnt_d = cnt_q;      q_d = q_q;      r_d = r_q;       p_d = p_q;
    p2_d = p2_q;        t_d = t_q;      i_d = i_q;       j_d = j_q;
    sgn_d = sgn_q;      n_d = n_q;      status_d = status_q;
    pos1_d = pos1_q;    pos2_d = pos2_q;
    dec_adv = 1'b0;     start_fix = 1'b0;
    case (state_q)
      IDLE: if (in_valid) begin
        w_d = W; div_d = W; rem_d = '0; cnt_d = '0;
        n_d = '0; status_d = 2'd0; pos1_d = '0; pos2_d = '0;
        state_d = DIV;
      end
      DIV: begin
        div_d = div_q_n; rem_d = div_rem_n; cnt_d = cnt_q + 1'b1;
        if (div_last) begin
          q_d = div_q_n[N_BITS-1:0];
          r_d = div_rem_n;
          state_d = CHK;
        end
      end
      CHK: if (r_q == '0) begin
        n_d = q_q; status_d = 2'd0; state_d = OUT;
      end else begin
        p_d = A_BITS'(1); i_d = L_BITS'(1); state_d = SEC;
      end
      SEC: if ((sec_hit_p || sec_hit_m) && cand_ok) begin
        pos1_d = pos_of(i_q, sec_hit_m); status_d = 2'd1; start_fix = 1'b1;
      end else if (i_q == L_BITS'(W_BITS)) begin
        if (DEC_EN != 0) begin
          i_d = L_BITS'(1); p_d = A_BITS'(1); sgn_d = 1'b0; state_d = DEC_O;
        end else begin
          n_d = q_q; status_d = 2'd3; state_d = OUT;
        end
      end else begin
        i_d = i_q + 1'b1; p_d = dbl_mod(p_q);
      end
      DEC_O: begin
        t_d = t_n; j_d = i_q + 1'b1; p2_d = dbl_mod(p_q); state_d = DEC_I;
      end
      DEC_I: if (j_q > L_BITS'(W_BITS)) begin
        dec_adv = 1'b1;
      end else if ((dec_hit_p || dec_hit_m) && cand_ok) begin
        pos1_d = pos_of(i_q, sgn_q); pos2_d = pos_of(j_q, dec_hit_m);
        status_d = 2'd2; start_fix = 1'b1;
      end else if (j_q == L_BITS'(W_BITS)) begin
        dec_adv = 1'b1;
      end else begin
        j_d = j_q + 1'b1; p2_d = dbl_mod(p2_q);
      end
      FIX: begin
        div_d = div_q_n; rem_d = div_rem_n; cnt_d = cnt_q + 1'b1;
        if (div_last) begin
          // A remainder here means the repair was bogus: fall back to the raw quotient
          if (div_rem_n == '0) begin
            n_d = div_q_n[N_BITS-1:0];
          end else begin
            n_d = q_q; status_d = 2'd3;
          end
          state_d = OUT;
        end
      end
      OUT: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (start_fix) begin
      div_d = cand[W_BITS-1:0]; rem_d = '0; cnt_d = '0; state_d = FIX;
    end
    if (dec_adv) begin
      if (!sgn_q) begin
        sgn_d = 1'b1; state_d = DEC_O;
      end else if (i_q == L_BITS'(W_BITS)) begin
        n_d = q_q; status_d = 2'd3; state_d = OUT;
      end else begin
        sgn_d = 1'b0; i_d = i_q + 1'b1; p_d = dbl_mod(p_q); state_d = DEC_O;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;  w_q <= '0;    div_q <= '0;  rem_q <= '0;
      cnt_q <= '0;      q_q <= '0;    r_q <= '0;    p_q <= '0;
      p2_q <= '0;       t_q <= '0;    i_q <= '0;    j_q <= '0;
      sgn_q <= 1'b0;    n_q <= '0;    status_q <= 2'd0;
      pos1_q <= '0;     pos2_q <= '0;
    end else begin
      state_q <= state_d;  w_q <= w_d;    div_q <= div_d;  rem_q <= rem_d;
      cnt_q <= cnt_d;      q_q <= q_d;    r_q <= r_d;      p_q <= p_d;
      p2_q <= p2_d;        t_q <= t_d;    i_q <= i_d;      j_q <= j_d;
      sgn_q <= sgn_d;      n_q <= n_d;    status_q <= status_d;
      pos1_q <= pos1_d;    pos2_q <= pos2_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign N         = n_q;
  assign status    = status_q;
  assign pos1      = pos1_q;
  assign pos2      = pos2_q;

endmodule
